regfile_access_ctrl: RTL and testbench

Access controller for the 32×64-bit integer register file that sits between decode and `user_editable_register`. It tracks destination registers with pending writes in a scoreboard and stalls decode on RAW/WAW hazards. It arbitrates the single register-file write port between the ALU and load writeback paths, using a one-entry skid buffer. It also counts stall cycles for performance debug.

---
 rtl/regfile_access_ctrl.sv | 131 +++++++++++++
 tb/tb_regfile_access_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_ctrl.sv
// Register-file access controller: busy scoreboard with RAW/WAW issue stalls,
// mem/ALU write-port arbitration through a one-entry skid, stall counter.
// Optional operand forwarding from the write port: define REGFILE_BYPASS_EN.
module regfile_access_ctrl #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rs1,
    input  logic [4:0]      issue_rs2,
    input  logic [4:0]      issue_rd,
    input  logic            issue_uses_rs1,
    input  logic            issue_uses_rs2,
    input  logic            issue_writes_rd,
    output logic            issue_ready,
    output logic [4:0]      rf_raddr1,
    output logic [4:0]      rf_raddr2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    output logic [XLEN-1:0] op1_data,
    output logic [XLEN-1:0] op2_data,
    input  logic            alu_wb_valid,
    input  logic [4:0]      alu_wb_rd,
    input  logic [XLEN-1:0] alu_wb_data,
    output logic            alu_wb_ready,
    input  logic            mem_wb_valid,
    input  logic [4:0]      mem_wb_rd,
    input  logic [XLEN-1:0] mem_wb_data,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [31:0]     stall_count
);

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

    logic [NREG-1:0] busy, busy_next;
    logic            skid_full;
    wb_req_t         skid;
    wb_req_t         win;
    logic            win_vld;
    logic            byp1, byp2, hazard, fire, alu_acc, skid_load, skid_drain;

`ifdef REGFILE_BYPASS_EN
    // A source being committed this cycle is read straight off the write port.
    assign byp1 = rf_we && (rf_waddr == issue_rs1) && (issue_rs1 != 5'd0);
    assign byp2 = rf_we && (rf_waddr == issue_rs2) && (issue_rs2 != 5'd0);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign hazard = (issue_uses_rs1  && busy[issue_rs1] && !byp1) ||
                    (issue_uses_rs2  && busy[issue_rs2] && !byp2) ||
                    (issue_writes_rd && busy[issue_rd]);

    assign issue_ready = !hazard;
    assign fire        = issue_valid && issue_ready;
    assign rf_raddr1   = issue_rs1;
    assign rf_raddr2   = issue_rs2;
    assign op1_data    = byp1 ? rf_wdata : rf_rdata1;
    assign op2_data    = byp2 ? rf_wdata : rf_rdata2;

    assign alu_wb_ready = !skid_full;
    assign alu_acc      = alu_wb_valid && !skid_full;
    assign skid_load    = mem_wb_valid && alu_acc;
    assign skid_drain   = !mem_wb_valid && skid_full;

    always_comb begin
        win_vld = 1'b0;
        win     = '0;
        if (mem_wb_valid) begin
            win_vld = 1'b1;
            win     = '{rd: mem_wb_rd, data: mem_wb_data};
        end else if (skid_full) begin
            win_vld = 1'b1;
            win     = skid;
        end else if (alu_acc) begin
            win_vld = 1'b1;
            win     = '{rd: alu_wb_rd, data: alu_wb_data};
        end
    end

    // Clear first so a same-edge set on the same index survives.
    always_comb begin
        busy_next = busy;
        if (rf_we)
            busy_next[rf_waddr] = 1'b0;
        if (fire && issue_writes_rd && (issue_rd != 5'd0))
            busy_next[issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy      <= '0;
            skid_full <= 1'b0;
            skid      <= '0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
        end else begin
            busy <= busy_next;
            if (skid_load) begin
                skid_full <= 1'b1;
                skid      <= '{rd: alu_wb_rd, data: alu_wb_data};
            end else if (skid_drain) begin
                skid_full <= 1'b0;
            end
            // Winners targeting x0 are consumed without a write.
            rf_we <= win_vld && (win.rd != 5'd0);
            if (win_vld && (win.rd != 5'd0)) begin
                rf_waddr <= win.rd;
                rf_wdata <= win.data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_count <= '0;
        else if (issue_valid && !issue_ready && (stall_count != 32'hFFFF_FFFF))
            stall_count <= stall_count + 32'd1;
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: behavioural scoreboard/queue model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_regfile_access_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid, issue_uses_rs1, issue_uses_rs2, issue_writes_rd;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        issue_ready;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [63:0] rf_rdata1, rf_rdata2, op1_data, op2_data;
    logic        alu_wb_valid, alu_wb_ready, mem_wb_valid;
    logic [4:0]  alu_wb_rd, mem_wb_rd;
    logic [63:0] alu_wb_data, mem_wb_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [31:0] stall_count;

    always #5 clk = ~clk;

    regfile_access_ctrl dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_uses_rs1(issue_uses_rs1),
        .issue_uses_rs2(issue_uses_rs2), .issue_writes_rd(issue_writes_rd),
        .issue_ready(issue_ready), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .op1_data(op1_data), .op2_data(op2_data),
        .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
        .alu_wb_ready(alu_wb_ready),
        .mem_wb_valid(mem_wb_valid), .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .stall_count(stall_count)
    );

    // Environment register file, written by the DUT write port.
    logic [63:0] rf_mem [32];
    assign rf_rdata1 = rf_mem[rf_raddr1];
    assign rf_rdata2 = rf_mem[rf_raddr2];
    always @(posedge clk) if (rf_we) rf_mem[rf_waddr] <= rf_wdata;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed { logic [4:0] rd; logic [63:0] d; } wb_s;
    bit          m_busy [32];
    wb_s         skid_q [$];
    bit          m_we    = 1'b0;
    logic [4:0]  m_waddr = '0;
    logic [63:0] m_wdata = '0;
    logic [31:0] m_stall = '0;
    logic [63:0] m_rf [32];

    function automatic bit fwd(input logic [4:0] rs);
`ifdef REGFILE_BYPASS_EN
        return m_we && (m_waddr == rs) && (rs != 0);
`else
        return (rs == 5'd31) && 1'b0;
`endif
    endfunction

    function automatic bit m_ready();
        bit h;
        h = (issue_uses_rs1 && m_busy[issue_rs1] && !fwd(issue_rs1)) ||
            (issue_uses_rs2 && m_busy[issue_rs2] && !fwd(issue_rs2)) ||
            (issue_writes_rd && m_busy[issue_rd]);
        return !h;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            skid_q.delete();
            m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_stall = '0;
        end else begin
            bit fire, acc, wv;
            wb_s w;
            fire = issue_valid && m_ready();
            acc  = alu_wb_valid && (skid_q.size() == 0);
            if (issue_valid && !m_ready() && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (m_we) begin
                m_rf[m_waddr]   = m_wdata;
                m_busy[m_waddr] = 1'b0;
            end
            if (fire && issue_writes_rd && issue_rd != 0) m_busy[issue_rd] = 1'b1;
            wv = 1'b1;
            w  = '0;
            if (mem_wb_valid) begin
                w = '{mem_wb_rd, mem_wb_data};
                if (acc) skid_q.push_back('{alu_wb_rd, alu_wb_data});
            end else if (skid_q.size() > 0) begin
                w = skid_q.pop_front();
            end else if (acc) begin
                w = '{alu_wb_rd, alu_wb_data};
            end else begin
                wv = 1'b0;
            end
            m_we = wv && (w.rd != 0);
            if (m_we) begin m_waddr = w.rd; m_wdata = w.d; end
        end
    end

    always @(negedge clk) begin
        chk("issue_ready", issue_ready, m_ready());
        chk("alu_wb_ready", alu_wb_ready, skid_q.size() == 0);
        chk("rf_we", rf_we, m_we);
        chk("stall_count", stall_count, m_stall);
        if (m_we) begin
            chk("rf_waddr", rf_waddr, m_waddr);
            chk("rf_wdata", rf_wdata, m_wdata);
        end
        if (issue_valid) begin
            chk("rf_raddr1", rf_raddr1, issue_rs1);
            chk("rf_raddr2", rf_raddr2, issue_rs2);
            chk("op1_data", op1_data, fwd(issue_rs1) ? m_wdata : m_rf[issue_rs1]);
            chk("op2_data", op2_data, fwd(issue_rs2) ? m_wdata : m_rf[issue_rs2]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
        issue_uses_rs1 = 0; issue_uses_rs2 = 0; issue_writes_rd = 0;
        alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0;
        mem_wb_valid = 0; mem_wb_rd = 0; mem_wb_data = 0;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic u1, input logic u2, input logic wr);
        issue_valid = 1; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd;
        issue_uses_rs1 = u1; issue_uses_rs2 = u2; issue_writes_rd = wr;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [63:0] d);
        alu_wb_valid = 1; alu_wb_rd = rd; alu_wb_data = d;
    endtask

    task automatic mem(input logic [4:0] rd, input logic [63:0] d);
        mem_wb_valid = 1; mem_wb_rd = rd; mem_wb_data = d;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic at_neg();
        @(negedge clk); #1;
    endtask

    initial begin
        foreach (rf_mem[i]) begin rf_mem[i] = '0; m_rf[i] = '0; end
        idle();
        #1 reset = 1'b0;
        step(); step();
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_waddr", rf_waddr, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_stall", stall_count, 0);
        chk("rst_issue_ready", issue_ready, 1);
        chk("rst_alu_ready", alu_wb_ready, 1);
        reset = 1'b1;

        // RAW on x3
        step(); issue(0, 0, 3, 0, 0, 1);
        at_neg; chk("raw_first_ready", issue_ready, 1);
        step(); issue(3, 0, 0, 1, 0, 0); alu(3, 64'h1234);
        at_neg; chk("raw_stall", issue_ready, 0);
        step(); alu_wb_valid = 0;
        at_neg;
        chk("raw_we", rf_we, 1); chk("raw_waddr", rf_waddr, 3); chk("raw_wdata", rf_wdata, 64'h1234);
`ifdef REGFILE_BYPASS_EN
        chk("raw_byp_ready", issue_ready, 1); chk("raw_byp_op1", op1_data, 64'h1234);
        step(); idle();
`else
        chk("raw_nobyp_stall", issue_ready, 0);
        step();
        at_neg; chk("raw_late_ready", issue_ready, 1); chk("raw_rf_op1", op1_data, 64'h1234);
        step(); idle();
`endif

        // Collision: mem wins, ALU goes to skid
        mem(4, 64'hAA); alu(6, 64'hBB);
        at_neg; chk("col_alu_ready", alu_wb_ready, 1);
        step(); idle();
        at_neg; chk("col_we", rf_we, 1); chk("col_waddr_mem", rf_waddr, 4);
        chk("col_wdata_mem", rf_wdata, 64'hAA); chk("col_skid_full", alu_wb_ready, 0);
        step();
        at_neg; chk("col_waddr_skid", rf_waddr, 6); chk("col_wdata_skid", rf_wdata, 64'hBB);
        chk("col_skid_empty", alu_wb_ready, 1);

        // Mem keeps priority while skid holds x10; x12 waits for ready
        step(); mem(9, 64'h1); alu(10, 64'h2);
        step(); mem(11, 64'h3); alu(12, 64'h4);
        at_neg; chk("starve_ready", alu_wb_ready, 0); chk("starve_w9", rf_waddr, 9);
        step(); mem_wb_valid = 0;
        at_neg; chk("starve_w11", rf_waddr, 11);
        step();
        at_neg; chk("drain_w10", rf_waddr, 10); chk("drain_d10", rf_wdata, 64'h2);
        step(); idle();
        at_neg; chk("late_w12", rf_waddr, 12); chk("late_d12", rf_wdata, 64'h4);

        // x0 destination and writeback
        step(); issue(0, 0, 0, 1, 0, 1); alu(0, 64'h55);
        at_neg; chk("x0_ready", issue_ready, 1); chk("x0_alu_ready", alu_wb_ready, 1);
        step(); alu_wb_valid = 0;
        at_neg; chk("x0_no_we", rf_we, 0); chk("x0_busy", issue_ready, 1);
        chk("x0_alu_ready2", alu_wb_ready, 1);

        // Commit to x7 coinciding with an issue writing x7: busy stays set
        step(); idle(); alu(7, 64'h77);
        step(); idle(); issue(0, 0, 7, 0, 0, 1);
        at_neg; chk("waw_commit", rf_waddr, 7); chk("waw_issue", issue_ready, 1);
        step(); issue(7, 0, 0, 1, 0, 0);
        at_neg; chk("waw_set_wins", issue_ready, 0);

        // Stall counter saturation under a held hazard
        step();
        force dut.stall_count = 32'hFFFF_FFFE;
        m_stall = 32'hFFFF_FFFE;
        #1 release dut.stall_count;
        repeat (5) step();
        at_neg; chk("stall_sat", stall_count, 32'hFFFF_FFFF);

        // Reset mid-stream while the skid holds x5
        step(); mem(13, 64'h13); alu(5, 64'h55);
        step(); mem_wb_valid = 0; alu_wb_valid = 0;
        #1 mem(14, 64'h14);
        at_neg; chk("pre_rst_skid", alu_wb_ready, 0);
        reset = 1'b0;
        #1;
        chk("mid_rst_we", rf_we, 0); chk("mid_rst_alu_ready", alu_wb_ready, 1);
        chk("mid_rst_issue_ready", issue_ready, 1); chk("mid_rst_stall", stall_count, 0);
        step(); idle(); reset = 1'b1;
        step();
        at_neg; chk("post_rst_no_drain", rf_we, 0); chk("post_rst_stall", stall_count, 0);
        for (int i = 1; i < 32; i++) begin
            step(); issue(i[4:0], i[4:0], 0, 1, 1, 0);
            at_neg; chk("post_rst_busy", issue_ready, 1);
        end
        step(); idle();
        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
